// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, step states,
// control-word bit positions and the per-opcode final-step lookup.
package control_sequencer_pkg;

  localparam int CTRL_W = 32;
  localparam int OP_W   = 5;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_RLST = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_WAIT = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam int B_PCOUT     = 0;
  localparam int B_PCIN      = 1;
  localparam int B_INCPC     = 2;
  localparam int B_MARIN     = 3;
  localparam int B_MDRIN     = 4;
  localparam int B_MDROUT    = 5;
  localparam int B_READ      = 6;
  localparam int B_WRITE     = 7;
  localparam int B_IRIN      = 8;
  localparam int B_YIN       = 9;
  localparam int B_ZIN       = 10;
  localparam int B_ZLOWOUT   = 11;
  localparam int B_ZHIGHOUT  = 12;
  localparam int B_HIIN      = 13;
  localparam int B_HIOUT     = 14;
  localparam int B_LOIN      = 15;
  localparam int B_LOOUT     = 16;
  localparam int B_GRA       = 17;
  localparam int B_GRB       = 18;
  localparam int B_GRC       = 19;
  localparam int B_RIN       = 20;
  localparam int B_ROUT      = 21;
  localparam int B_BAOUT     = 22;
  localparam int B_COUT      = 23;
  localparam int B_CONIN     = 24;
  localparam int B_INPORTOUT = 25;
  localparam int B_OUTPORTIN = 26;

  function automatic logic [CTRL_W-1:0] cb(input int idx);
    return 32'd1 << idx;
  endfunction

  // Final step of each opcode; nop, halt and undefined codes end at T2.
  function automatic state_t last_step(input logic [OP_W-1:0] op);
    state_t s;
    s = S_T2;
    if (op == OP_LD || op == OP_ST)
      s = S_T7;
    else if (op == OP_LDI)
      s = S_T5;
    else if (op >= OP_ADD && op <= OP_ORI)
      s = S_T5;
    else if (op == OP_MUL || op == OP_DIV || op == OP_BR)
      s = S_T6;
    else if (op == OP_NEG || op == OP_NOT || op == OP_JAL)
      s = S_T4;
    else if (op == OP_JR || (op >= OP_IN && op <= OP_MFLO))
      s = S_T3;
    return s;
  endfunction

endpackage

// File: rtl/control_sequencer_ctrl_decode.sv
// Combinational decode of step state, opcode and CON into the control word.
// Ports: i_state, i_opcode, i_con in; o_ctrl (32), o_alu_op (5) out.
module ctrl_decode
  import control_sequencer_pkg::*;
(
  input  state_t            i_state,
  input  logic [OP_W-1:0]   i_opcode,
  input  logic              i_con,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [OP_W-1:0]   o_alu_op
);

  logic w_r, w_imm, w_ld, w_ldi, w_st, w_md, w_nn;
  logic w_br, w_jr, w_jal, w_in, w_out, w_mfhi, w_mflo;

  assign w_r    = (i_opcode >= OP_ADD) && (i_opcode <= OP_RLST);
  assign w_imm  = (i_opcode >= OP_ADDI) && (i_opcode <= OP_ORI);
  assign w_ld   = (i_opcode == OP_LD);
  assign w_ldi  = (i_opcode == OP_LDI);
  assign w_st   = (i_opcode == OP_ST);
  assign w_md   = (i_opcode == OP_MUL) || (i_opcode == OP_DIV);
  assign w_nn   = (i_opcode == OP_NEG) || (i_opcode == OP_NOT);
  assign w_br   = (i_opcode == OP_BR);
  assign w_jr   = (i_opcode == OP_JR);
  assign w_jal  = (i_opcode == OP_JAL);
  assign w_in   = (i_opcode == OP_IN);
  assign w_out  = (i_opcode == OP_OUT);
  assign w_mfhi = (i_opcode == OP_MFHI);
  assign w_mflo = (i_opcode == OP_MFLO);

  always_comb begin
    o_ctrl   = '0;
    o_alu_op = '0;
    unique case (i_state)
      S_T0: o_ctrl = cb(B_PCOUT) | cb(B_MARIN)
                   | cb(B_INCPC) | cb(B_ZIN);
      S_T1: o_ctrl = cb(B_ZLOWOUT) | cb(B_PCIN)
                   | cb(B_READ) | cb(B_MDRIN);
      S_T2: o_ctrl = cb(B_MDROUT) | cb(B_IRIN);
      S_T3: begin
        unique case (1'b1)
          w_r, w_imm:
            o_ctrl = cb(B_GRB) | cb(B_ROUT) | cb(B_YIN);
          w_ld, w_ldi, w_st:
            o_ctrl = cb(B_GRB) | cb(B_BAOUT) | cb(B_YIN);
          w_md:
            o_ctrl = cb(B_GRA) | cb(B_ROUT) | cb(B_YIN);
          w_nn: begin
            o_ctrl   = cb(B_GRB) | cb(B_ROUT) | cb(B_ZIN);
            o_alu_op = i_opcode;
          end
          w_br:
            o_ctrl = cb(B_GRA) | cb(B_ROUT) | cb(B_CONIN);
          w_jr:
            o_ctrl = cb(B_GRA) | cb(B_ROUT) | cb(B_PCIN);
          w_jal:
            o_ctrl = cb(B_PCOUT) | cb(B_GRB) | cb(B_RIN);
          w_in:
            o_ctrl = cb(B_INPORTOUT) | cb(B_GRA) | cb(B_RIN);
          w_out:
            o_ctrl = cb(B_GRA) | cb(B_ROUT) | cb(B_OUTPORTIN);
          w_mfhi:
            o_ctrl = cb(B_HIOUT) | cb(B_GRA) | cb(B_RIN);
          w_mflo:
            o_ctrl = cb(B_LOOUT) | cb(B_GRA) | cb(B_RIN);
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          w_r: begin
            o_ctrl   = cb(B_GRC) | cb(B_ROUT) | cb(B_ZIN);
            o_alu_op = i_opcode;
          end
          w_imm: begin
            o_ctrl   = cb(B_COUT) | cb(B_ZIN);
            o_alu_op = i_opcode;
          end
          w_ld, w_ldi, w_st: begin
            o_ctrl   = cb(B_COUT) | cb(B_ZIN);
            o_alu_op = OP_ADD;
          end
          w_md: begin
            o_ctrl   = cb(B_GRB) | cb(B_ROUT) | cb(B_ZIN);
            o_alu_op = i_opcode;
          end
          w_nn:
            o_ctrl = cb(B_ZLOWOUT) | cb(B_GRA) | cb(B_RIN);
          w_br:
            o_ctrl = cb(B_PCOUT) | cb(B_YIN);
          w_jal:
            o_ctrl = cb(B_GRA) | cb(B_ROUT) | cb(B_PCIN);
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          w_r, w_imm, w_ldi:
            o_ctrl = cb(B_ZLOWOUT) | cb(B_GRA) | cb(B_RIN);
          w_ld, w_st:
            o_ctrl = cb(B_ZLOWOUT) | cb(B_MARIN);
          w_md:
            o_ctrl = cb(B_ZLOWOUT) | cb(B_LOIN);
          w_br: begin
            o_ctrl   = cb(B_COUT) | cb(B_ZIN);
            o_alu_op = OP_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          w_ld:
            o_ctrl = cb(B_READ) | cb(B_MDRIN);
          w_st:
            o_ctrl = cb(B_GRA) | cb(B_ROUT) | cb(B_MDRIN);
          w_md:
            o_ctrl = cb(B_ZHIGHOUT) | cb(B_HIIN);
          // Branch taken only when the latched condition holds.
          w_br:
            if (i_con)
              o_ctrl = cb(B_ZLOWOUT) | cb(B_PCIN);
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          w_ld:
            o_ctrl = cb(B_MDROUT) | cb(B_GRA) | cb(B_RIN);
          w_st:
            o_ctrl = cb(B_WRITE);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Step sequencer (T0-T7, HALT; WAIT when CTRL_STEP_EN is defined).
// Ports: i_clk, i_clear, i_opcode, i_con, i_stop, [i_step]; o_run, o_ctrl, o_alu_op.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_clear,
  input  logic [OP_W-1:0]   i_opcode,
  input  logic              i_con,
  input  logic              i_stop,
`ifdef CTRL_STEP_EN
  input  logic              i_step,
`endif
  output logic              o_run,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [OP_W-1:0]   o_alu_op
);

`ifdef CTRL_STEP_EN
  localparam state_t ENTRY = S_WAIT;
`else
  localparam state_t ENTRY = S_T0;
`endif

  state_t r_state;
  state_t w_next;
  logic   w_last;

  assign w_last = (r_state == last_step(i_opcode));

  always_ff @(posedge i_clk) begin
    if (i_clear)
      r_state <= S_T0;
    else
      r_state <= w_next;
  end

  // Stop is looked at only on the edge that would start the next fetch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HALT: w_next = S_HALT;
      S_WAIT: begin
`ifdef CTRL_STEP_EN
        if (i_step)
          w_next = S_T0;
`else
        w_next = S_T0;
`endif
      end
      default: begin
        if (w_last)
          w_next = (i_opcode == OP_HALT || i_stop) ? S_HALT : ENTRY;
        else
          w_next = state_t'(r_state + 4'd1);
      end
    endcase
  end

  assign o_run = (r_state != S_HALT);

  ctrl_decode u_decode (
    .i_state  (r_state),
    .i_opcode (i_opcode),
    .i_con    (i_con),
    .o_ctrl   (o_ctrl),
    .o_alu_op (o_alu_op)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-opcode step tables compared cycle by cycle.
// Ports of the DUT are all driven; CTRL_STEP_EN adds the Step tests.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        con = 1'b0;
  logic        stop = 1'b0;
  logic [4:0]  op = 5'd26;
`ifdef CTRL_STEP_EN
  logic        step = 1'b1;
`endif
  logic        run;
  logic [31:0] ctrl;
  logic [4:0]  alu;

  int checks = 0;
  int failures = 0;

  logic [37:0] exp_q[$];
  bit          exp_halt;

  control_sequencer dut (
    .i_clk    (clk),
    .i_clear  (clear),
    .i_opcode (op),
    .i_con    (con),
    .i_stop   (stop),
`ifdef CTRL_STEP_EN
    .i_step   (step),
`endif
    .o_run    (run),
    .o_ctrl   (ctrl),
    .o_alu_op (alu)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int i);
    return 32'd1 << i;
  endfunction

  localparam logic [31:0] T0W =
    (32'd1 << B_PCOUT) | (32'd1 << B_MARIN) |
    (32'd1 << B_INCPC) | (32'd1 << B_ZIN);
  localparam logic [31:0] T1W =
    (32'd1 << B_ZLOWOUT) | (32'd1 << B_PCIN) |
    (32'd1 << B_READ) | (32'd1 << B_MDRIN);
  localparam logic [31:0] T2W =
    (32'd1 << B_MDROUT) | (32'd1 << B_IRIN);

  task automatic push(input logic [31:0] c,
                      input logic [4:0] a = 5'd0);
    exp_q.push_back({1'b1, a, c});
  endtask

  // Expected step list for one instruction, straight from the step tables.
  task automatic model(input logic [4:0] o, input logic c);
    int n;
    n = int'(o);
    exp_q.delete();
    exp_halt = (n == 27);
    push(T0W); push(T1W); push(T2W);
    if (n >= 3 && n <= 11) begin
      push(w(B_GRB) | w(B_ROUT) | w(B_YIN));
      push(w(B_GRC) | w(B_ROUT) | w(B_ZIN), o);
      push(w(B_ZLOWOUT) | w(B_GRA) | w(B_RIN));
    end else if (n >= 12 && n <= 14) begin
      push(w(B_GRB) | w(B_ROUT) | w(B_YIN));
      push(w(B_COUT) | w(B_ZIN), o);
      push(w(B_ZLOWOUT) | w(B_GRA) | w(B_RIN));
    end else if (n <= 2) begin
      push(w(B_GRB) | w(B_BAOUT) | w(B_YIN));
      push(w(B_COUT) | w(B_ZIN), 5'd3);
      if (n == 1) begin
        push(w(B_ZLOWOUT) | w(B_GRA) | w(B_RIN));
      end else begin
        push(w(B_ZLOWOUT) | w(B_MARIN));
        if (n == 0) begin
          push(w(B_READ) | w(B_MDRIN));
          push(w(B_MDROUT) | w(B_GRA) | w(B_RIN));
        end else begin
          push(w(B_GRA) | w(B_ROUT) | w(B_MDRIN));
          push(w(B_WRITE));
        end
      end
    end else if (n == 15 || n == 16) begin
      push(w(B_GRA) | w(B_ROUT) | w(B_YIN));
      push(w(B_GRB) | w(B_ROUT) | w(B_ZIN), o);
      push(w(B_ZLOWOUT) | w(B_LOIN));
      push(w(B_ZHIGHOUT) | w(B_HIIN));
    end else if (n == 17 || n == 18) begin
      push(w(B_GRB) | w(B_ROUT) | w(B_ZIN), o);
      push(w(B_ZLOWOUT) | w(B_GRA) | w(B_RIN));
    end else if (n == 19) begin
      push(w(B_GRA) | w(B_ROUT) | w(B_CONIN));
      push(w(B_PCOUT) | w(B_YIN));
      push(w(B_COUT) | w(B_ZIN), 5'd3);
      push(c ? (w(B_ZLOWOUT) | w(B_PCIN)) : 32'd0);
    end else if (n == 20) begin
      push(w(B_GRA) | w(B_ROUT) | w(B_PCIN));
    end else if (n == 21) begin
      push(w(B_PCOUT) | w(B_GRB) | w(B_RIN));
      push(w(B_GRA) | w(B_ROUT) | w(B_PCIN));
    end else if (n == 22) begin
      push(w(B_INPORTOUT) | w(B_GRA) | w(B_RIN));
    end else if (n == 23) begin
      push(w(B_GRA) | w(B_ROUT) | w(B_OUTPORTIN));
    end else if (n == 24) begin
      push(w(B_HIOUT) | w(B_GRA) | w(B_RIN));
    end else if (n == 25) begin
      push(w(B_LOOUT) | w(B_GRA) | w(B_RIN));
    end
  endtask

  task automatic check(input string tag, input logic [37:0] e);
    checks++;
    assert ({run, alu, ctrl} === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, {run, alu, ctrl}, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    stop  = 1'b0;
    tick();
    check({tag, "_clr"}, {1'b1, 5'd0, T0W});
    clear = 1'b0;
  endtask

  // Starts in T0; stop_at raises and holds Stop from that step index.
  task automatic run_instr(input logic [4:0] o, input logic c,
                           input int stop_at);
    bit halts;
    op  = o;
    con = c;
    model(o, c);
    halts = exp_halt || (stop_at >= 0 && stop_at < exp_q.size());
    foreach (exp_q[i]) begin
      if (i == stop_at)
        stop = 1'b1;
      check($sformatf("op%0d_c%0d_t%0d", o, c, i), exp_q[i]);
      tick();
    end
    if (halts) begin
      repeat (2) begin
        check($sformatf("op%0d_halt", o), {1'b0, 5'd0, 32'd0});
        tick();
      end
      do_clear("halt");
    end else begin
`ifdef CTRL_STEP_EN
      check($sformatf("op%0d_wait", o), {1'b1, 5'd0, 32'd0});
      tick();
`endif
      check($sformatf("op%0d_next_t0", o), {1'b1, 5'd0, T0W});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int o, c, s;
    clear = 1'b1;
    tick();
    tick();
    check("reset", {1'b1, 5'd0, T0W});
    clear = 1'b0;

    run_instr(5'd3, 1'b0, -1);
    run_instr(5'd0, 1'b0, -1);
    run_instr(5'd19, 1'b0, -1);
    run_instr(5'd19, 1'b1, -1);
    run_instr(5'd15, 1'b0, 4);
    run_instr(5'd27, 1'b0, -1);
    run_instr(5'd26, 1'b0, -1);
    run_instr(5'd30, 1'b0, -1);

    op = 5'd2;
    model(5'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("st_mid_t%0d", i), exp_q[i]);
      if (i < 5)
        tick();
    end
    do_clear("st_mid");

`ifdef CTRL_STEP_EN
    op = 5'd26;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("step_fetch_t%0d", i),
            (i == 0) ? {1'b1, 5'd0, T0W} :
            (i == 1) ? {1'b1, 5'd0, T1W} :
                       {1'b1, 5'd0, T2W});
      if (i == 2)
        step = 1'b0;
      tick();
    end
    repeat (5) begin
      check("step_wait", {1'b1, 5'd0, 32'd0});
      tick();
    end
    step = 1'b1;
    check("step_wait_last", {1'b1, 5'd0, 32'd0});
    tick();
    check("step_t0", {1'b1, 5'd0, T0W});
`endif

    repeat (80) begin
      o = $urandom_range(0, 31);
      c = $urandom_range(0, 1);
      s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
      run_instr(5'(o), 1'(c), s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide parameter/constant: none beyond the shared package; Ctrl bit map is fixed by the package.
REQ-002 Clock  in  1  single rising-edge clock.
REQ-003 Clear  in  1  synchronous, active-high reset.
REQ-004 Opcode  in  5  decoded instruction opcode; stable from step T3 onward.
REQ-005 CON  in  1  branch-condition flag; sampled in T6 of a branch.
REQ-006 Stop  in  1  halt request; sampled only on entry to T0.
REQ-007 Run  out  1  high in every state except HALT.
REQ-008 Ctrl  out  32  one-hot-per-bit control word: PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, InPortout, OutPortin; unused bits 0.
REQ-009 AluOp  out  5  ALU operation code; 0 outside ALU steps.

Function
REQ-010 Outputs SHALL be Moore: decoded combinationally from the state register only (CON excepted at T6 branch).
REQ-011 Fetch SHALL be T0: PCout MARin IncPC Zin; T1: Zlowout PCin Read MDRin; T2: MDRout IRin.
REQ-012 R-format (00011-01011): T3 Grb Rout Yin; T4 Grc Rout Zin AluOp=Opcode; T5 Zlowout Gra Rin; then T0.
REQ-013 addi/andi/ori (01100-01110): T3 Grb Rout Yin; T4 Cout Zin AluOp=Opcode; T5 Zlowout Gra Rin.
REQ-014 ld (00000): T3 Grb BAout Yin; T4 Cout Zin AluOp=00011; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
REQ-015 ldi (00001): T3-T4 as ld; T5 Zlowout Gra Rin.
REQ-016 st (00010): T3-T5 as ld; T6 Gra Rout MDRin; T7 Write.
REQ-017 mul/div (01111,10000): T3 Gra Rout Yin; T4 Grb Rout Zin AluOp=Opcode; T5 Zlowout LOin; T6 Zhighout HIin.
REQ-018 neg/not (10001,10010): T3 Grb Rout Zin AluOp=Opcode; T4 Zlowout Gra Rin.
REQ-019 branch (10011): T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin AluOp=00011; T6 Zlowout PCin only if CON=1, else no control bits.
REQ-020 jr (10100): T3 Gra Rout PCin. jal (10101): T3 PCout Grb Rin; T4 Gra Rout PCin.
REQ-021 in/out/mfhi/mflo (10110-11001): single T3 step: InPortout|Gra Rout OutPortin|HIout|LOout, plus Gra Rin where a register is written.
REQ-022 nop (11010) and undefined opcodes (11100-11111) SHALL return T2->T0 with no execute step.
REQ-023 halt (11011) SHALL enter HALT after T2; HALT drives Ctrl=0, AluOp=0, Run=0, held until Clear.
REQ-024 Stop=1 on T0 entry SHALL go to HALT instead of T0; Stop elsewhere ignored; the current instruction always completes.
REQ-025 Every instruction's last step SHALL transition to T0 on the next edge; no step repeats.

Reset
REQ-026 Clear=1 at any edge, including mid-instruction or in HALT, SHALL force state T0 next cycle; Clear outranks Stop and Step.
REQ-027 During and after reset Run=1, Ctrl reflects T0, AluOp=0.

Configuration
REQ-028 CTRL_STEP_EN defined: adds input Step (1 bit); on T0 entry state holds in WAIT (Ctrl=0, Run=1) until a cycle with Step=1, then T0 next cycle.
REQ-029 CTRL_STEP_EN undefined: no Step port, no WAIT state; T0 follows immediately.

Structure
REQ-030 Shared package SHALL hold opcode constants, the state enum (T0-T7, WAIT, HALT), and Ctrl bit index constants.
REQ-031 One sub-module, ctrl_decode: pure combinational state+Opcode+CON -> Ctrl/AluOp; the sequencer keeps only the state register and next-state logic.

Verification
REQ-032 Clear then Opcode=00011 (add) -> Ctrl shows T0..T5 over 6 cycles, AluOp=00011 exactly at T4, back to T0 at cycle 7.
REQ-033 ld (00000) -> 8-cycle sequence; Read asserted at T1 and T6 only, Gra Rin at T7.
REQ-034 branch with CON=0 vs CON=1 -> PCin at T6 only when CON=1; both return to T0 after 7 cycles.
REQ-035 Stop=1 raised during T4 of mul -> instruction finishes T6 (HIin), then HALT, Run=0; Clear -> T0, Run=1.
REQ-036 Clear asserted at T5 of st -> Write never asserted; next cycle T0.
REQ-037 CTRL_STEP_EN defined, Step held 0 for 5 cycles after nop -> Ctrl=0 throughout; Step=1 -> T0 next cycle.
